// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the RV32I cores: FSM states, opcodes and datapath select codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        RST_IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
        EXECI, ALUWB, BRANCH, JAL, JALR_ADR, LUI, AUIPC, ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/imm_src_dec.sv
// Opcode -> immediate format decoder, shared by the multicycle and single-cycle cores.
module imm_src_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (opcode)
            OP_STORE:         imm_src = IMM_S;
            OP_BR:            imm_src = IMM_B;
            OP_JAL:           imm_src = IMM_J;
            OP_LUI, OP_AUIPC: imm_src = IMM_U;
            default:          imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control FSM: Moore datapath controls decoded from the state register.
// Define MCTRL_MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE until mem_ready.
module mc_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [1:0] ALUOp,
    output logic       instr_done,
    output logic       illegal_instr
);

    state_t state;
    logic   pc_update;
    logic   branch;
    logic   mem_ok;
    logic   known_op;

`ifdef MCTRL_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif

    always_comb begin
        case (opcode)
            OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: known_op = 1'b1;
            default:                           known_op = 1'b0;
        endcase
    end

    imm_src_dec u_imm_src_dec (
        .opcode  (opcode),
        .imm_src (ImmSrc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RST_IDLE;
        end else begin
            case (state)
                RST_IDLE: state <= FETCH;
                FETCH:    if (mem_ok) state <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state <= MEMADR;
                        OP_R:              state <= EXECR;
                        OP_I:              state <= EXECI;
                        OP_BR:             state <= BRANCH;
                        OP_JAL:            state <= JAL;
                        OP_JALR:           state <= JALR_ADR;
                        OP_LUI:            state <= LUI;
                        OP_AUIPC:          state <= AUIPC;
                        default: begin
                            if (ILLEGAL_HALT) state <= ILLEGAL;
                            else              state <= FETCH;
                        end
                    endcase
                end
                MEMADR: begin
                    if (opcode == OP_STORE) state <= MEMWRITE;
                    else                    state <= MEMREAD;
                end
                MEMREAD:  if (mem_ok) state <= MEMWB;
                MEMWRITE: if (mem_ok) state <= FETCH;
                MEMWB, ALUWB, BRANCH:         state <= FETCH;
                EXECR, EXECI, LUI, AUIPC, JAL: state <= ALUWB;
                // JALR's second cycle (PC <= ALUOut, ALUOut <= OldPC+4) is identical to JAL.
                JALR_ADR: state <= JAL;
                ILLEGAL:  state <= ILLEGAL;
                default:  state <= FETCH;
            endcase
        end
    end

    always_comb begin
        pc_update     = 1'b0;
        branch        = 1'b0;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        MemWrite      = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RS2;
        ALUOp         = ALUOP_ADD;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        case (state)
            FETCH: begin
                IRWrite   = mem_ok;
                pc_update = mem_ok;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_IMM;
                instr_done = !known_op && !ILLEGAL_HALT;
            end
            MEMADR, JALR_ADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ok;
            end
            EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALUOP_FUNCT;
            end
            EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUOp      = ALUOP_BR;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
            end
            AUIPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            ILLEGAL: illegal_instr = 1'b1;
            default: ;
        endcase
    end

    assign PCWrite = pc_update | (branch & branch_taken);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: one instance halts on illegal opcodes, one treats them as NOP.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    // {PCWrite,AdrSrc,IRWrite,MemWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUOp,instr_done,illegal_instr}
    logic [17:0] o1, o0;

    logic [35:0] eq[$];
    string       tq[$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.ILLEGAL_HALT(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .PCWrite(o1[17]), .AdrSrc(o1[16]), .IRWrite(o1[15]),
        .MemWrite(o1[14]), .RegWrite(o1[13]), .ResultSrc(o1[12:11]), .ALUSrcA(o1[10:9]),
        .ALUSrcB(o1[8:7]), .ImmSrc(o1[6:4]), .ALUOp(o1[3:2]), .instr_done(o1[1]),
        .illegal_instr(o1[0])
    );

    mc_ctrl_fsm #(.ILLEGAL_HALT(1'b0)) dut_nop (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .PCWrite(o0[17]), .AdrSrc(o0[16]), .IRWrite(o0[15]),
        .MemWrite(o0[14]), .RegWrite(o0[13]), .ResultSrc(o0[12:11]), .ALUSrcA(o0[10:9]),
        .ALUSrcB(o0[8:7]), .ImmSrc(o0[6:4]), .ALUOp(o0[3:2]), .instr_done(o0[1]),
        .illegal_instr(o0[0])
    );

    function automatic logic [17:0] mk(input int pcw, input int adr, input int irw,
                                       input int mw, input int rw, input int rs,
                                       input int a, input int b, input int imm,
                                       input int op, input int done, input int ill);
        return {1'(pcw), 1'(adr), 1'(irw), 1'(mw), 1'(rw), 2'(rs), 2'(a), 2'(b),
                3'(imm), 2'(op), 1'(done), 1'(ill)};
    endfunction

    function automatic logic [17:0] f_fetch(input int imm);
        return mk(1, 0, 1, 0, 0, 2, 0, 2, imm, 0, 0, 0);
    endfunction

    function automatic logic [17:0] f_dec(input int imm);
        return mk(0, 0, 0, 0, 0, 0, 1, 1, imm, 0, 0, 0);
    endfunction

    function automatic logic [17:0] f_wb(input int imm);
        return mk(0, 0, 0, 0, 1, 0, 0, 0, imm, 0, 1, 0);
    endfunction

    task automatic cyc(input string tag, input logic [17:0] e1, input logic [17:0] e0);
        eq.push_back({e1, e0});
        tq.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc1(input string tag, input logic [17:0] e);
        cyc(tag, e, e);
    endtask

    always @(negedge clk) begin
        if (eq.size() > 0) begin
            logic [35:0] e;
            string       t;
            e = eq.pop_front();
            t = tq.pop_front();
            checks = checks + 2;
            if (o1 !== e[35:18]) begin
                errors = errors + 1;
                $display("FAIL %s halt=1 got=%b want=%b", t, o1, e[35:18]);
            end
            if (o0 !== e[17:0]) begin
                errors = errors + 1;
                $display("FAIL %s halt=0 got=%b want=%b", t, o0, e[17:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [17:0] z;
        z = '0;
        reset = 1'b1;
        opcode = 7'b0;
        branch_taken = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc1("reset_hold", z);
        reset = 1'b0;
        cyc1("rst_idle", z);

        opcode = 7'b0110011;
        cyc1("add_fetch", f_fetch(0));
        cyc1("add_decode", f_dec(0));
        cyc1("add_execr", mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 2, 0, 0));
        cyc1("add_aluwb", f_wb(0));

        opcode = 7'b0010011;
        cyc1("addi_fetch", f_fetch(0));
        cyc1("addi_decode", f_dec(0));
        cyc1("addi_execi", mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 2, 0, 0));
        cyc1("addi_aluwb", f_wb(0));

        opcode = 7'b1100011;
        branch_taken = 1'b1;
        cyc1("beq_t_fetch", f_fetch(2));
        cyc1("beq_t_decode", f_dec(2));
        cyc1("beq_t_branch", mk(1, 0, 0, 0, 0, 0, 2, 0, 2, 1, 1, 0));
        branch_taken = 1'b0;
        cyc1("beq_n_fetch", f_fetch(2));
        cyc1("beq_n_decode", f_dec(2));
        cyc1("beq_n_branch", mk(0, 0, 0, 0, 0, 0, 2, 0, 2, 1, 1, 0));

        opcode = 7'b1100111;
        cyc1("jalr_fetch", f_fetch(0));
        cyc1("jalr_decode", f_dec(0));
        cyc1("jalr_adr", mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
        cyc1("jalr_pc", mk(1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
        cyc1("jalr_aluwb", f_wb(0));

        opcode = 7'b1101111;
        cyc1("jal_fetch", f_fetch(3));
        cyc1("jal_decode", f_dec(3));
        cyc1("jal_jal", mk(1, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0));
        cyc1("jal_aluwb", f_wb(3));

        opcode = 7'b0110111;
        cyc1("lui_fetch", f_fetch(4));
        cyc1("lui_decode", f_dec(4));
        cyc1("lui_lui", mk(0, 0, 0, 0, 0, 0, 3, 1, 4, 0, 0, 0));
        cyc1("lui_aluwb", f_wb(4));

        opcode = 7'b0010111;
        cyc1("auipc_fetch", f_fetch(4));
        cyc1("auipc_decode", f_dec(4));
        cyc1("auipc_auipc", mk(0, 0, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0));
        cyc1("auipc_aluwb", f_wb(4));

        opcode = 7'b0100011;
        cyc1("sw_fetch", f_fetch(1));
        cyc1("sw_decode", f_dec(1));
        cyc1("sw_memadr", mk(0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0));
        cyc1("sw_memwrite", mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0));

        opcode = 7'b0000011;
        cyc1("lw_fetch", f_fetch(0));
        cyc1("lw_decode", f_dec(0));
        cyc1("lw_memadr", mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
        cyc1("lw_memread", mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc1("lw_memwb", mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));

        // Abort a load in MEMADR, then check the restart sequence.
        cyc1("lw2_fetch", f_fetch(0));
        cyc1("lw2_decode", f_dec(0));
        reset = 1'b1;
        cyc1("rst_mid_memadr", z);
        reset = 1'b0;
        cyc1("rst_mid_idle", z);
        cyc1("lw3_fetch", f_fetch(0));
        cyc1("lw3_decode", f_dec(0));
        cyc1("lw3_memadr", mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
        cyc1("lw3_memread", mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc1("lw3_memwb", mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));

        opcode = 7'b1111111;
        cyc1("ill_fetch", f_fetch(0));
        cyc("ill_decode", f_dec(0), mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0));
        for (int i = 0; i < 12; i++) begin
            cyc("ill_hold", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),
                (i % 2 == 0) ? f_fetch(0) : mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0));
        end
        reset = 1'b1;
        cyc1("ill_reset", z);
        reset = 1'b0;
        cyc1("ill_rst_idle", z);

`ifdef MCTRL_MEM_WAIT_EN
        opcode = 7'b0100011;
        mem_ready = 1'b0;
        cyc1("wait_fetch_stall", mk(0, 0, 0, 0, 0, 2, 0, 2, 1, 0, 0, 0));
        mem_ready = 1'b1;
        cyc1("wait_fetch", f_fetch(1));
        cyc1("wait_decode", f_dec(1));
        cyc1("wait_memadr", mk(0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc1("wait_memwrite_stall", mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        end
        mem_ready = 1'b1;
        cyc1("wait_memwrite_done", mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0));
        cyc1("wait_next_fetch", f_fetch(1));
`else
        opcode = 7'b0100011;
        mem_ready = 1'b0;
        cyc1("nowait_fetch", f_fetch(1));
        cyc1("nowait_decode", f_dec(1));
        cyc1("nowait_memadr", mk(0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0));
        cyc1("nowait_memwrite", mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0));
        cyc1("nowait_next_fetch", f_fetch(1));
        mem_ready = 1'b1;
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
